// File: rtl/imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module   : imm_extend_pipe
// Purpose  : Registered immediate extender with prefix merge and valid/ready.
// Revision : 1.0
// ============================================================================
module imm_extend_pipe #(
    parameter int DATA_WIDTH    = 32,
    parameter int BRANCH_SHIFT  = 0,
    parameter int PREFIX_OPCODE = 31
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic                  in_unsigned,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_immediate,
    output logic [1:0]            out_kind,
    output logic                  out_prefixed
);

    localparam logic [1:0] c_KIND_DATA = 2'd0;
    localparam logic [1:0] c_KIND_ALU  = 2'd1;
    localparam logic [1:0] c_KIND_CTRL = 2'd2;
    localparam logic [1:0] c_KIND_PASS = 2'd3;

    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_imm;
    logic [1:0]            r_out_kind;
    logic                  r_out_prefixed;
    logic                  r_prefix_pending;
    logic [26:0]           r_payload;

    logic                  w_out_valid_d;
    logic [DATA_WIDTH-1:0] w_out_imm_d;
    logic [1:0]            w_out_kind_d;
    logic                  w_out_prefixed_d;
    logic                  w_prefix_pending_d;
    logic [26:0]           w_payload_d;

    logic [4:0]            w_opcode;
    logic                  w_is_prefix;
    logic                  w_accept;
    logic [1:0]            w_kind;
    logic [26:0]           w_field;
    logic [4:0]            w_fw;
    logic [4:0]            w_top;
    logic [5:0]            w_ext_from;
    logic                  w_sign;
    logic [DATA_WIDTH-1:0] w_raw;
    logic [DATA_WIDTH-1:0] w_ext;
    logic [DATA_WIDTH-1:0] w_imm;

    assign in_ready      = !r_out_valid || out_ready;
    assign out_valid     = r_out_valid;
    assign out_immediate = r_out_imm;
    assign out_kind      = r_out_kind;
    assign out_prefixed  = r_out_prefixed;

    // Field selection; w_top is the sign bit position of the bare field.
    always_comb begin
        w_opcode    = in_instr[31:27];
        w_is_prefix = (w_opcode == 5'(PREFIX_OPCODE));
        w_kind      = c_KIND_PASS;
        w_field     = 27'd0;
        w_fw        = 5'd0;
        w_top       = 5'd0;
        if (!w_is_prefix) begin
            case (w_opcode)
                5'd0, 5'd2: begin
                    w_kind  = c_KIND_DATA;
                    w_field = {11'd0, in_instr[21:6]};
                    w_fw    = 5'd16;
                    w_top   = 5'd15;
                end
                5'd3, 5'd12: begin
                    w_kind  = c_KIND_ALU;
                    w_field = {15'd0, in_instr[11:0]};
                    w_fw    = 5'd12;
                    w_top   = 5'd11;
                end
                5'd13, 5'd18: begin
                    w_kind  = c_KIND_CTRL;
                    w_field = in_instr[26:0];
                    w_fw    = 5'd27;
                    w_top   = 5'd26;
                end
                default: begin
                    w_kind = c_KIND_PASS;
                end
            endcase
        end
    end

    // Bits of {payload, field} above DATA_WIDTH fall off the shift, which is
    // exactly the truncation wanted when the concatenation is wider.
    always_comb begin
        if (r_prefix_pending) begin
            w_raw      = (DATA_WIDTH'(r_payload) << w_fw) | DATA_WIDTH'(w_field);
            w_ext_from = {1'b0, w_fw} + 6'd27;
            w_sign     = !in_unsigned && r_payload[26];
        end else begin
            w_raw      = DATA_WIDTH'(w_field);
            w_ext_from = {1'b0, w_fw};
            w_sign     = !in_unsigned && w_field[w_top];
        end
        w_ext = w_sign ? (w_raw | ({DATA_WIDTH{1'b1}} << w_ext_from)) : w_raw;
        case (w_kind)
            c_KIND_CTRL: w_imm = w_ext << BRANCH_SHIFT;
            c_KIND_PASS: w_imm = DATA_WIDTH'(in_instr);
            default:     w_imm = w_ext;
        endcase
    end

    always_comb begin
        w_accept           = in_valid && in_ready;
        w_out_valid_d      = r_out_valid;
        w_out_imm_d        = r_out_imm;
        w_out_kind_d       = r_out_kind;
        w_out_prefixed_d   = r_out_prefixed;
        w_prefix_pending_d = r_prefix_pending;
        w_payload_d        = r_payload;
        if (flush) begin
            w_out_valid_d      = 1'b0;
            w_prefix_pending_d = 1'b0;
        end else begin
            if (out_ready) begin
                w_out_valid_d = 1'b0;
            end
            if (w_accept) begin
                if (w_is_prefix) begin
                    w_prefix_pending_d = 1'b1;
                    w_payload_d        = in_instr[26:0];
                end else begin
                    w_out_valid_d      = 1'b1;
                    w_out_imm_d        = w_imm;
                    w_out_kind_d       = w_kind;
                    w_out_prefixed_d   = r_prefix_pending && (w_kind != c_KIND_PASS);
                    w_prefix_pending_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out_valid      <= 1'b0;
            r_out_imm        <= '0;
            r_out_kind       <= c_KIND_DATA;
            r_out_prefixed   <= 1'b0;
            r_prefix_pending <= 1'b0;
            r_payload        <= 27'd0;
        end else begin
            r_out_valid      <= w_out_valid_d;
            r_out_imm        <= w_out_imm_d;
            r_out_kind       <= w_out_kind_d;
            r_out_prefixed   <= w_out_prefixed_d;
            r_prefix_pending <= w_prefix_pending_d;
            r_payload        <= w_payload_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_extend_pipe
// Purpose  : Directed and random checks of imm_extend_pipe against a model.
// Revision : 1.0
// ============================================================================
module tb_imm_extend_pipe;

    localparam int c_DW     = 32;
    localparam int c_BSHIFT = 2;
    localparam int c_PREFIX = 31;

    typedef struct {
        logic [63:0] imm;
        logic [1:0]  kind;
        logic        pref;
    } res_t;

    logic            clock;
    logic            reset;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic            in_unsigned;
    logic            out_valid;
    logic            out_ready;
    logic [c_DW-1:0] out_immediate;
    logic [1:0]      out_kind;
    logic            out_prefixed;

    int          n_tests = 0;
    int          n_fail  = 0;
    res_t        sb[$];
    bit          m_pending = 1'b0;
    logic [26:0] m_payload = 27'd0;

    imm_extend_pipe #(
        .DATA_WIDTH   (c_DW),
        .BRANCH_SHIFT (c_BSHIFT),
        .PREFIX_OPCODE(c_PREFIX)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_unsigned  (in_unsigned),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_immediate(out_immediate),
        .out_kind     (out_kind),
        .out_prefixed (out_prefixed)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Immediate computed as an integer: build the value, apply two's
    // complement interpretation, reduce modulo 2^DW, then scale branches.
    function automatic res_t ref_imm(input logic [31:0] instr, input bit uns,
                                     input bit pend, input logic [26:0] pay);
        res_t        r;
        longint      val;
        longint      f;
        int          w;
        logic [63:0] u;
        logic [63:0] mask;
        mask = (c_DW == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << c_DW) - 64'd1);
        case (instr[31:27])
            5'd0, 5'd2:   begin r.kind = 2'd0; f = longint'(instr[21:6]); w = 16; end
            5'd3, 5'd12:  begin r.kind = 2'd1; f = longint'(instr[11:0]); w = 12; end
            5'd13, 5'd18: begin r.kind = 2'd2; f = longint'(instr[26:0]); w = 27; end
            default: begin
                r.kind = 2'd3;
                r.imm  = 64'(instr) & mask;
                r.pref = 1'b0;
                return r;
            end
        endcase
        val = f;
        if (pend) begin
            val = longint'(pay) * (longint'(1) << w) + f;
            w   = w + 27;
        end
        if (!uns && val >= (longint'(1) << (w - 1)))
            val = val - (longint'(1) << w);
        u = 64'(val) & mask;
        if (r.kind == 2'd2)
            u = (u * (64'd1 << c_BSHIFT)) & mask;
        r.imm  = u;
        r.pref = pend;
        return r;
    endfunction

    // One clock: drive, check outputs against the scoreboard, advance model.
    task automatic cycle(input bit v, input logic [31:0] instr, input bit uns,
                         input bit rdy, input bit fl);
        bit   exp_ready;
        res_t r;
        in_valid    = v;
        in_instr    = instr;
        in_unsigned = uns;
        out_ready   = rdy;
        flush       = fl;
        @(negedge clock);
        exp_ready = (sb.size() == 0) || rdy;
        chk("in_ready", 64'(in_ready), 64'(exp_ready));
        chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
        if (sb.size() != 0) begin
            chk("out_immediate", 64'(out_immediate), sb[0].imm);
            chk("out_kind", 64'(out_kind), 64'(sb[0].kind));
            chk("out_prefixed", 64'(out_prefixed), 64'(sb[0].pref));
        end
        if (fl) begin
            sb.delete();
            m_pending = 1'b0;
        end else begin
            if (rdy && sb.size() != 0)
                void'(sb.pop_front());
            if (v && exp_ready) begin
                if (instr[31:27] == 5'(c_PREFIX)) begin
                    m_pending = 1'b1;
                    m_payload = instr[26:0];
                end else begin
                    r = ref_imm(instr, uns, m_pending, m_payload);
                    sb.push_back(r);
                    m_pending = 1'b0;
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [63:0] imm,
                              input logic [1:0] kind, input bit pref);
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_imm"}, 64'(out_immediate), imm);
        chk({tag, "_kind"}, 64'(out_kind), 64'(kind));
        chk({tag, "_pref"}, 64'(out_prefixed), 64'(pref));
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        flush    = 1'b0;
        reset    = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        sb.delete();
        m_pending = 1'b0;
    endtask

    logic [31:0] ops [8] = '{32'd0, 32'd2, 32'd3, 32'd12, 32'd13, 32'd18, 32'd31, 32'd7};

    initial begin
        logic [31:0] rnd;
        logic [31:0] op;
        reset       = 1'b1;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_instr    = 32'd0;
        in_unsigned = 1'b0;
        out_ready   = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_imm", 64'(out_immediate), 64'd0);
        chk("rst_kind", 64'(out_kind), 64'd0);
        chk("rst_pref", 64'(out_prefixed), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        reset = 1'b0;

        cycle(1, 32'h18000FFF, 0, 1, 0); expect_out("alu_s", 64'hFFFFFFFF, 2'd1, 0);
        cycle(1, 32'h18000FFF, 1, 1, 0); expect_out("alu_u", 64'h00000FFF, 2'd1, 0);
        cycle(1, 32'h00200000, 0, 1, 0); expect_out("data", 64'hFFFF8000, 2'd0, 0);
        cycle(1, 32'h28001234, 0, 1, 0); expect_out("pass", 64'h28001234, 2'd3, 0);
        cycle(1, 32'h68000010, 0, 1, 0); expect_out("br_pos", 64'h00000040, 2'd2, 0);
        cycle(1, 32'h6FFFFFFF, 0, 1, 0); expect_out("br_neg", 64'hFFFFFFFC, 2'd2, 0);

        cycle(1, 32'hF8000ABC, 0, 1, 0);
        chk("prefix_no_out", 64'(out_valid), 64'd0);
        cycle(1, 32'h18000123, 0, 1, 0); expect_out("pfx_merge", 64'h00ABC123, 2'd1, 1);
        cycle(1, 32'h18000123, 0, 1, 0); expect_out("pfx_after", 64'h00000123, 2'd1, 0);

        // Backpressure: three blocked cycles, then four back-to-back results.
        cycle(1, 32'h18000001, 0, 1, 0);
        repeat (3) cycle(1, 32'h18000777, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(1, 32'h18000010 + 32'(i), 0, 1, 0);
        cycle(0, 32'd0, 0, 1, 0);

        cycle(1, 32'hF8000FFF, 0, 1, 0);
        cycle(0, 32'd0, 0, 1, 1);
        cycle(1, 32'h18000FFF, 0, 1, 0); expect_out("flush_pfx", 64'hFFFFFFFF, 2'd1, 0);
        cycle(0, 32'd0, 0, 1, 0);

        // Asynchronous reset while an entry is held.
        cycle(1, 32'h18000FFF, 0, 0, 0);
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_imm", 64'(out_immediate), 64'd0);
        do_reset();

        // Reset drops a pending prefix.
        cycle(1, 32'hF8000ABC, 0, 1, 0);
        do_reset();
        cycle(1, 32'h18000123, 0, 1, 0); expect_out("rst_pfx", 64'h00000123, 2'd1, 0);

        for (int i = 0; i < 600; i++) begin
            rnd = $urandom();
            op  = ops[$urandom_range(0, 7)];
            if (op == 32'd7) op = 32'($urandom_range(0, 31));
            cycle($urandom_range(0, 9) < 7, {op[4:0], rnd[26:0]}, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
        end
        cycle(0, 32'd0, 0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
